// File: rtl/mac_feeder.sv
// Streams operand pairs from two square-matrix stores into a MAC for C = X * Y.
// Latency: first pair is registered out the cycle after start is accepted, then one pair per clock.
// Backpressure: none; the MAC consumes every pair unconditionally, writes only land while idle.
module mac_feeder #(
    parameter int DW   = 16,
    parameter int MAXN = 8,
    parameter int IW   = $clog2(MAXN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [IW-1:0] wr_row,
    input  logic [IW-1:0] wr_col,
    input  logic [DW-1:0] wr_data,
    input  logic [3:0]    n,
    input  logic          start,
    output logic          busy,
    output logic          err,
    output logic          sof,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic          vld,
    output logic          eod,
    output logic [IW-1:0] row_idx,
    output logic [IW-1:0] col_idx,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [3:0] N_MAX = 4'(MAXN);

    // Operand stores; deliberately not reset so contents survive rst.
    logic [DW-1:0] r_x [MAXN][MAXN];
    logic [DW-1:0] r_y [MAXN][MAXN];

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_i, r_j, r_k, r_nm1;
    logic [IW-1:0] w_i_nxt, w_j_nxt, w_k_nxt, w_nm1_nxt;

    logic          r_busy, r_err, r_sof, r_vld, r_eod, r_done;
    logic [DW-1:0] r_a, r_b;
    logic [IW-1:0] r_row, r_col;

    logic          w_busy_nxt, w_err_nxt, w_sof_nxt, w_vld_nxt, w_eod_nxt, w_done_nxt;
    logic [DW-1:0] w_a_nxt, w_b_nxt;
    logic [IW-1:0] w_row_nxt, w_col_nxt;
    logic          w_load;
    logic          w_n_ok;
    logic          w_last;

    assign w_n_ok = (n != 4'd0) && (n <= N_MAX);
    assign w_last = (r_i == r_nm1) && (r_j == r_nm1) && (r_k == r_nm1);

    // Operand store writes, locked out whenever a sequence is active.
    always_ff @(posedge clk) begin
        if (wr_en && (r_state == S_IDLE)) begin
            if (wr_sel) begin
                r_y[wr_row][wr_col] <= wr_data;
            end else begin
                r_x[wr_row][wr_col] <= wr_data;
            end
        end
    end

    // Next-state, index walk (k fastest, then j, then i) and next output values.
    // Indices always name the pair currently on the outputs, so the output
    // registers are loaded from the store using the next indices.
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_nm1_nxt   = r_nm1;
        w_busy_nxt  = r_busy;
        w_err_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_vld_nxt   = 1'b0;
        w_sof_nxt   = 1'b0;
        w_eod_nxt   = 1'b0;
        w_a_nxt     = '0;
        w_b_nxt     = '0;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_n_ok) begin
                        w_state_nxt = S_RUN;
                        w_nm1_nxt   = IW'(n - 4'd1);
                        w_i_nxt     = '0;
                        w_j_nxt     = '0;
                        w_k_nxt     = '0;
                        w_busy_nxt  = 1'b1;
                        w_load      = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_load = 1'b1;
                    if (r_k == r_nm1) begin
                        w_k_nxt = '0;
                        if (r_j == r_nm1) begin
                            w_j_nxt = '0;
                            w_i_nxt = r_i + 1'b1;
                        end else begin
                            w_j_nxt = r_j + 1'b1;
                        end
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        if (w_load) begin
            w_vld_nxt = 1'b1;
            w_a_nxt   = r_x[w_i_nxt][w_k_nxt];
            w_b_nxt   = r_y[w_k_nxt][w_j_nxt];
            w_sof_nxt = (w_k_nxt == '0);
            w_eod_nxt = (w_k_nxt == w_nm1_nxt);
            w_row_nxt = w_i_nxt;
            w_col_nxt = w_j_nxt;
        end
    end

    // State, indices and registered outputs; rst aborts any sequence silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_nm1   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_vld   <= 1'b0;
            r_sof   <= 1'b0;
            r_eod   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_nm1   <= w_nm1_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
            r_done  <= w_done_nxt;
            r_vld   <= w_vld_nxt;
            r_sof   <= w_sof_nxt;
            r_eod   <= w_eod_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    assign busy    = r_busy;
    assign err     = r_err;
    assign done    = r_done;
    assign vld     = r_vld;
    assign sof     = r_sof;
    assign eod     = r_eod;
    assign A       = r_a;
    assign B       = r_b;
    assign row_idx = r_row;
    assign col_idx = r_col;

endmodule

// File: tb/tb_mac_feeder.sv
module tb_mac_feeder;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        wr_sel;
    logic [2:0]  wr_row;
    logic [2:0]  wr_col;
    logic [15:0] wr_data;
    logic [3:0]  n;
    logic        start;
    logic        busy;
    logic        err;
    logic        sof;
    logic [15:0] A;
    logic [15:0] B;
    logic        vld;
    logic        eod;
    logic [2:0]  row_idx;
    logic [2:0]  col_idx;
    logic        done;

    mac_feeder #(.DW(16), .MAXN(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .n       (n),
        .start   (start),
        .busy    (busy),
        .err     (err),
        .sof     (sof),
        .A       (A),
        .B       (B),
        .vld     (vld),
        .eod     (eod),
        .row_idx (row_idx),
        .col_idx (col_idx),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [15:0] a;
        logic [15:0] b;
        logic        sof;
        logic        eod;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        busy;
        logic        done;
        logic        err;
    } rec_t;

    // Model state: operand matrices, expected per-cycle output stream, held indices.
    logic [15:0] mx [8][8];
    logic [15:0] my [8][8];
    rec_t        q[$];
    logic [2:0]  m_row;
    logic [2:0]  m_col;

    int checks = 0;
    int errors = 0;
    bit en_cmp = 0;
    int vld_cnt = 0;
    int lg_a[$];
    int lg_b[$];
    int lg_sof[$];
    int lg_eod[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every cycle against the model stream; when nothing is expected the block must be quiet.
    always @(negedge clk) begin
        if (en_cmp) begin
            rec_t e;
            if (q.size() != 0) begin
                e = q.pop_front();
            end else begin
                e.vld = 0; e.a = 0; e.b = 0; e.sof = 0; e.eod = 0;
                e.row = m_row; e.col = m_col; e.busy = 0; e.done = 0; e.err = 0;
            end
            chk("vld", {31'd0, vld}, {31'd0, e.vld});
            chk("A", {16'd0, A}, {16'd0, e.a});
            chk("B", {16'd0, B}, {16'd0, e.b});
            chk("sof", {31'd0, sof}, {31'd0, e.sof});
            chk("eod", {31'd0, eod}, {31'd0, e.eod});
            chk("row_idx", {29'd0, row_idx}, {29'd0, e.row});
            chk("col_idx", {29'd0, col_idx}, {29'd0, e.col});
            chk("busy", {31'd0, busy}, {31'd0, e.busy});
            chk("done", {31'd0, done}, {31'd0, e.done});
            chk("err", {31'd0, err}, {31'd0, e.err});
            if (vld === 1'b1) begin
                vld_cnt++;
                lg_a.push_back(int'(A));
                lg_b.push_back(int'(B));
                lg_sof.push_back(int'(sof));
                lg_eod.push_back(int'(eod));
            end
        end
    end

    task automatic clear_log();
        vld_cnt = 0;
        lg_a.delete(); lg_b.delete(); lg_sof.delete(); lg_eod.delete();
    endtask

    // Store write; the model only takes it when no sequence is outstanding.
    task automatic wr(input bit sel, input int r, input int c, input int d);
        wr_en = 1; wr_sel = sel; wr_row = 3'(r); wr_col = 3'(c); wr_data = 16'(d);
        @(posedge clk);
        if (q.size() == 0) begin
            if (sel) my[r][c] = 16'(d);
            else     mx[r][c] = 16'(d);
        end
        #1 wr_en = 0;
    endtask

    // Start pulse; model expands an accepted start into N^3 pairs plus a done cycle.
    task automatic go(input int nv);
        rec_t r;
        start = 1; n = 4'(nv);
        @(posedge clk);
        if (q.size() == 0) begin
            if (nv >= 1 && nv <= 8) begin
                for (int i = 0; i < nv; i++)
                    for (int j = 0; j < nv; j++)
                        for (int k = 0; k < nv; k++) begin
                            r.vld = 1; r.a = mx[i][k]; r.b = my[k][j];
                            r.sof = (k == 0); r.eod = (k == nv - 1);
                            r.row = 3'(i); r.col = 3'(j);
                            r.busy = 1; r.done = 0; r.err = 0;
                            q.push_back(r);
                        end
                m_row = 3'(nv - 1); m_col = 3'(nv - 1);
                r.vld = 0; r.a = 0; r.b = 0; r.sof = 0; r.eod = 0;
                r.row = m_row; r.col = m_col; r.busy = 0; r.done = 1; r.err = 0;
                q.push_back(r);
            end else begin
                r.vld = 0; r.a = 0; r.b = 0; r.sof = 0; r.eod = 0;
                r.row = m_row; r.col = m_col; r.busy = 0; r.done = 0; r.err = 1;
                q.push_back(r);
            end
        end
        #1 start = 0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 3000; t++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL wait_idle actual=%0d pending required=0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    // Hand-computed 2x2 stream for X=[[1,2],[3,4]], Y=[[5,6],[7,8]].
    task automatic chk_2x2_literal();
        int ea[8];
        int eb[8];
        ea = '{1, 2, 1, 2, 3, 4, 3, 4};
        eb = '{5, 7, 6, 8, 5, 7, 6, 8};
        chk("lit2x2_count", 32'(lg_a.size()), 32'd8);
        if (lg_a.size() == 8) begin
            for (int c = 0; c < 8; c++) begin
                chk("lit2x2_A", 32'(lg_a[c]), 32'(ea[c]));
                chk("lit2x2_B", 32'(lg_b[c]), 32'(eb[c]));
                chk("lit2x2_sof", 32'(lg_sof[c]), (c % 2 == 0) ? 32'd1 : 32'd0);
                chk("lit2x2_eod", 32'(lg_eod[c]), (c % 2 == 1) ? 32'd1 : 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1; wr_en = 0; wr_sel = 0; wr_row = 0; wr_col = 0; wr_data = 0;
        n = 0; start = 0; m_row = 0; m_col = 0;
        repeat (3) @(posedge clk);
        #1 en_cmp = 1;
        rst = 0;

        // Fill both stores completely.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                wr(0, r, c, r * 8 + c + 1);
                wr(1, r, c, 200 + r * 8 + c);
            end

        // Full size, with a stray start mid-run that must be ignored.
        clear_log();
        go(8);
        idle(20);
        go(3);
        wait_idle();
        chk("full_vld_count", 32'(vld_cnt), 32'd512);

        // 2x2 reference case.
        wr(0, 0, 0, 1); wr(0, 0, 1, 2); wr(0, 1, 0, 3); wr(0, 1, 1, 4);
        wr(1, 0, 0, 5); wr(1, 0, 1, 6); wr(1, 1, 0, 7); wr(1, 1, 1, 8);
        clear_log();
        go(2);
        wait_idle();
        chk_2x2_literal();

        // Rejected starts.
        go(0);
        idle(3);
        go(9);
        idle(3);
        go(15);
        idle(3);

        // 3x3 over mixed store contents.
        clear_log();
        go(3);
        wait_idle();
        chk("n3_vld_count", 32'(vld_cnt), 32'd27);

        // Write during a run must be dropped; rerun reproduces the stream.
        go(2);
        wr(0, 0, 0, 99);
        wr(1, 1, 1, 77);
        wait_idle();
        clear_log();
        go(2);
        wait_idle();
        chk_2x2_literal();

        // Reset on the third vld cycle, then restart.
        go(2);
        idle(2);
        rst = 1;
        @(posedge clk);
        q.delete(); m_row = 0; m_col = 0;
        #1 rst = 0;
        idle(3);
        clear_log();
        go(2);
        wait_idle();
        chk_2x2_literal();

        // Single element.
        wr(0, 0, 0, 12);
        wr(1, 0, 0, 15);
        clear_log();
        go(1);
        wait_idle();
        chk("n1_count", 32'(lg_a.size()), 32'd1);
        if (lg_a.size() == 1) begin
            chk("n1_A", 32'(lg_a[0]), 32'd12);
            chk("n1_B", 32'(lg_b[0]), 32'd15);
            chk("n1_sof", 32'(lg_sof[0]), 32'd1);
            chk("n1_eod", 32'(lg_eod[0]), 32'd1);
        end

        idle(4);
        en_cmp = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
